linebuf_sched: RTL and testbench

LINEBUF_SCHED -- requirements
Module: linebuf_sched

---
 rtl/linebuf_sched_if.sv | 26 ++
 rtl/linebuf_sched.sv | 160 ++++++++++++++++
 tb/tb_linebuf_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/linebuf_sched_if.sv
// Producer/consumer control and line-buffer address bus for linebuf_sched.
// master drives the strobes (producer/consumer side); slave is the scheduler.
interface linebuf_sched_if #(parameter int COL_W = 9);
  logic             frame_sync;
  logic             wr_start;
  logic             wr_en;
  logic             rd_start;
  logic             rd_en;
  logic             wr_we;
  logic [COL_W:0]   wr_addr;
  logic [COL_W:0]   rd_addr;
  logic             rd_valid;
  logic             rd_repeat;
  logic             overrun;
  logic [7:0]       ovr_cnt;

  modport master (
    output frame_sync, wr_start, wr_en, rd_start, rd_en,
    input  wr_we, wr_addr, rd_addr, rd_valid, rd_repeat, overrun, ovr_cnt
  );

  modport slave (
    input  frame_sync, wr_start, wr_en, rd_start, rd_en,
    output wr_we, wr_addr, rd_addr, rd_valid, rd_repeat, overrun, ovr_cnt
  );
endinterface

// File: rtl/linebuf_sched.sv
// Two-bank line-buffer scheduler: producer fills banks, consumer reads the
// oldest full bank, replaying the held bank when no new line is ready.
module linebuf_sched #(
  parameter int LINE_LEN = 512,
  parameter int COL_W    = 9
) (
  input  logic           clk,
  input  logic           reset,
  linebuf_sched_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} bank_st_e;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

  bank_st_e             st_q [2];
  bank_st_e             st_d [2];
  logic                 age_q, age_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]     wr_col_q, wr_col_d;
  logic                 wr_active_q, wr_active_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [COL_W-1:0]     rd_col_q, rd_col_d;
  logic                 rd_active_q, rd_active_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_repeat_q, rd_repeat_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           ovr_cnt_q, ovr_cnt_d;

  logic                 wr_we;
  logic                 any_full, any_empty, oldest, free_idx;

  assign wr_we = bus.wr_en & wr_active_q;

  always_comb begin
    st_d        = st_q;
    age_d       = age_q;
    wr_bank_d   = wr_bank_q;
    wr_col_d    = wr_col_q;
    wr_active_d = wr_active_q;
    rd_bank_d   = rd_bank_q;
    rd_col_d    = rd_col_q;
    rd_active_d = rd_active_q;
    rd_valid_d  = rd_valid_q;
    rd_repeat_d = rd_repeat_q;
    overrun_d   = 1'b0;
    ovr_cnt_d   = ovr_cnt_q;

    // Both sides decide on the pre-cycle bank states.
    any_full  = (st_q[0] == FULL) || (st_q[1] == FULL);
    any_empty = (st_q[0] == EMPTY) || (st_q[1] == EMPTY);
    oldest    = ((st_q[0] == FULL) && (st_q[1] == FULL)) ? age_q : (st_q[1] == FULL);
    free_idx  = (st_q[0] == EMPTY) ? 1'b0 : 1'b1;

    if (bus.rd_start) begin
      if (any_full) begin
        if (rd_valid_q) st_d[rd_bank_q] = EMPTY;
        st_d[oldest] = READ;
        rd_bank_d    = oldest;
        rd_col_d     = '0;
        rd_active_d  = 1'b1;
        rd_valid_d   = 1'b1;
        rd_repeat_d  = 1'b0;
      end else if (rd_valid_q) begin
        rd_col_d    = '0;
        rd_active_d = 1'b1;
        rd_repeat_d = 1'b1;
      end else begin
        rd_valid_d  = 1'b0;
        rd_active_d = 1'b0;
      end
    end else if (bus.rd_en && rd_active_q) begin
      if (rd_col_q == LAST_COL) begin
        rd_active_d = 1'b0;
        rd_col_d    = '0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end

    if (bus.wr_start) begin
      if (wr_active_q) begin
        wr_col_d = '0;
      end else if (any_empty) begin
        st_d[free_idx] = FILL;
        wr_bank_d      = free_idx;
        wr_active_d    = 1'b1;
        wr_col_d       = '0;
      end else begin
        overrun_d = 1'b1;
        if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end else if (wr_we) begin
      if (wr_col_q == LAST_COL) begin
        st_d[wr_bank_q] = FULL;
        wr_active_d     = 1'b0;
        wr_col_d        = '0;
        // Age points at this bank unless the other one is still waiting as FULL.
        if (st_d[~wr_bank_q] != FULL) age_d = wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    if (bus.frame_sync) begin
      st_d[0]     = EMPTY;
      st_d[1]     = EMPTY;
      age_d       = 1'b0;
      wr_col_d    = '0;
      wr_active_d = 1'b0;
      rd_col_d    = '0;
      rd_active_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_repeat_d = 1'b0;
      overrun_d   = 1'b0;
      ovr_cnt_d   = ovr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      age_q       <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_col_q    <= '0;
      wr_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= '0;
      rd_active_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_repeat_q <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= 8'd0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      age_q       <= age_d;
      wr_bank_q   <= wr_bank_d;
      wr_col_q    <= wr_col_d;
      wr_active_q <= wr_active_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      rd_active_q <= rd_active_d;
      rd_valid_q  <= rd_valid_d;
      rd_repeat_q <= rd_repeat_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign bus.wr_we     = wr_we;
  assign bus.wr_addr   = {wr_bank_q, wr_col_q};
  assign bus.rd_addr   = {rd_bank_q, rd_col_q};
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_repeat = rd_repeat_q;
  assign bus.overrun   = overrun_q;
  assign bus.ovr_cnt   = ovr_cnt_q;
endmodule

// File: tb/tb_linebuf_sched.sv
// Bench for linebuf_sched: directed scenarios plus random traffic, all
// cycles compared against a queue-based model of the bank scheduling rules.
module tb_linebuf_sched;
  localparam int LL = 512;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  linebuf_sched_if #(.COL_W(CW)) bus ();
  linebuf_sched #(.LINE_LEN(LL), .COL_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: FULL banks kept in completion order; the front is the oldest.
  int m_full[$];
  bit m_empty[2];
  int m_held, m_wbank, m_wcol, m_rbank, m_rcol, m_cnt;
  bit m_wact, m_ract, m_rep, m_ovr;

  task automatic model(input bit r, fs, ws, we, rs, re);
    bit e0, e1;
    int nfull;
    if (r) begin
      m_full = {}; m_empty[0] = 1; m_empty[1] = 1; m_held = -1;
      m_wbank = 0; m_wcol = 0; m_wact = 0; m_rbank = 0; m_rcol = 0;
      m_ract = 0; m_rep = 0; m_ovr = 0; m_cnt = 0;
    end else if (fs) begin
      m_full = {}; m_empty[0] = 1; m_empty[1] = 1; m_held = -1;
      m_wcol = 0; m_wact = 0; m_rcol = 0; m_ract = 0; m_rep = 0; m_ovr = 0;
    end else begin
      e0 = m_empty[0]; e1 = m_empty[1]; nfull = m_full.size();
      m_ovr = 0;
      if (rs) begin
        if (nfull > 0) begin
          if (m_held >= 0) m_empty[m_held] = 1;
          m_held = m_full.pop_front();
          m_rbank = m_held; m_rcol = 0; m_ract = 1; m_rep = 0;
        end else if (m_held >= 0) begin
          m_rcol = 0; m_ract = 1; m_rep = 1;
        end else m_ract = 0;
      end else if (re && m_ract) begin
        if (m_rcol == LL-1) begin m_ract = 0; m_rcol = 0; end
        else m_rcol++;
      end
      if (ws) begin
        if (m_wact) m_wcol = 0;
        else if (e0 || e1) begin
          m_wbank = e0 ? 0 : 1; m_empty[m_wbank] = 0; m_wact = 1; m_wcol = 0;
        end else begin
          m_ovr = 1; if (m_cnt < 255) m_cnt++;
        end
      end else if (we && m_wact) begin
        if (m_wcol == LL-1) begin m_full.push_back(m_wbank); m_wact = 0; m_wcol = 0; end
        else m_wcol++;
      end
    end
  endtask

  task automatic step(input bit r, fs, ws, we, rs, re);
    reset = r; bus.frame_sync = fs; bus.wr_start = ws; bus.wr_en = we;
    bus.rd_start = rs; bus.rd_en = re;
    #1;
    check("wr_we", bus.wr_we, int'(we && m_wact));
    @(posedge clk);
    model(r, fs, ws, we, rs, re);
    #1;
    check("wr_addr", bus.wr_addr, (m_wbank << CW) | m_wcol);
    check("rd_addr", bus.rd_addr, (m_rbank << CW) | m_rcol);
    check("rd_valid", bus.rd_valid, int'(m_held >= 0));
    check("rd_repeat", bus.rd_repeat, int'(m_rep));
    check("overrun", bus.overrun, int'(m_ovr));
    check("ovr_cnt", bus.ovr_cnt, m_cnt);
  endtask

  task automatic write_line();
    step(0, 0, 1, 0, 0, 0);
    repeat (LL) step(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b1; bus.frame_sync = 0; bus.wr_start = 0; bus.wr_en = 0;
    bus.rd_start = 0; bus.rd_en = 0;
    m_held = -1; m_wact = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_cnt", bus.ovr_cnt, 0);
    check("rst_waddr", bus.wr_addr, 0);

    // Basic line write then read.
    write_line();
    step(0, 0, 0, 0, 1, 0);
    check("t33_bank", bus.rd_addr[CW], 0);
    check("t33_valid", bus.rd_valid, 1);
    check("t33_rep", bus.rd_repeat, 0);
    for (int i = 0; i < LL; i++) begin
      check("t33_col", bus.rd_addr[CW-1:0], i);
      step(0, 0, 0, 0, 0, 1);
    end
    check("t33_wrap", bus.rd_addr[CW-1:0], 0);

    // Line doubling.
    step(0, 0, 0, 0, 1, 0);
    check("t34_rep", bus.rd_repeat, 1);
    check("t34_bank", bus.rd_addr[CW], 0);

    // Overrun and oldest-first selection.
    step(1, 0, 0, 0, 0, 0);
    write_line();
    write_line();
    step(0, 0, 1, 0, 0, 0);
    check("t35_ovr", bus.overrun, 1);
    check("t35_cnt", bus.ovr_cnt, 1);
    step(0, 0, 0, 0, 0, 0);
    check("t35_ovr_pulse", bus.overrun, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t35_bank", bus.rd_addr[CW], 0);

    // Saturation.
    repeat (300) step(0, 0, 1, 0, 0, 0);
    check("t36_sat", bus.ovr_cnt, 255);

    // frame_sync mid-write in bank 1.
    step(0, 0, 0, 0, 1, 0);
    check("t38_rbank1", bus.rd_addr[CW], 1);
    write_line();
    step(0, 0, 0, 0, 1, 0);
    check("t38_rbank0", bus.rd_addr[CW], 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (100) step(0, 0, 0, 1, 0, 0);
    check("t38_mid", bus.wr_addr, (1 << CW) | 100);
    step(0, 1, 0, 0, 0, 0);
    check("t38_fs_col", bus.wr_addr[CW-1:0], 0);
    check("t38_fs_valid", bus.rd_valid, 0);
    check("t38_fs_cnt", bus.ovr_cnt, 255);
    step(0, 0, 1, 0, 0, 0);
    check("t38_claim", bus.wr_addr, 0);

    // rd_start coinciding with completion of bank 1 replays bank 0.
    step(1, 0, 0, 0, 0, 0);
    write_line();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (LL-1) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check("t37_rep", bus.rd_repeat, 1);
    check("t37_bank0", bus.rd_addr[CW], 0);
    step(0, 0, 0, 0, 1, 0);
    check("t37_bank1", bus.rd_addr[CW], 1);
    check("t37_new", bus.rd_repeat, 0);

    // Random traffic.
    for (int c = 0; c < 40000; c++) begin
      step($urandom_range(0, 29999) == 0, $urandom_range(0, 9999) == 0,
           $urandom_range(0, 1499) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 1199) == 0, $urandom_range(0, 9) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
